disp_scan_mux: RTL and testbench

- Upstream stage of the 4-bit-to-7-segment decoder.
- Holds a packed multi-digit BCD/hex value and time-multiplexes it onto one shared 4-bit nibble bus, which feeds the decoder input.
- Drives one-hot digit enables for the common-cathode/anode drivers.
- New values are double-buffered and committed only at frame boundaries, so a refresh never shows half of one value and half of another.

---
 rtl/disp_scan_mux_if.sv | 22 ++
 rtl/disp_scan_mux.sv | 102 ++++++++++
 tb/tb_disp_scan_mux.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/disp_scan_mux_if.sv
// Bus bundle for disp_scan_mux: load/value/blank_mask in, nibble/digit_en/frame_tick out.
// The master side is whoever drives the value; the slave side is the scan mux itself.
interface disp_scan_mux_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     blank_mask;
    logic [3:0]            nibble;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_tick;

    modport master (
        output load, value, blank_mask,
        input  nibble, digit_en, frame_tick
    );

    modport slave (
        input  load, value, blank_mask,
        output nibble, digit_en, frame_tick
    );
endinterface

// File: rtl/disp_scan_mux.sv
// Multi-digit display scanner: double-buffered value, one shared nibble bus, one-hot enables.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module disp_scan_mux #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned GUARD    = 2
) (
    input logic              clk,
    input logic              rst_n,
    disp_scan_mux_if.slave   bus
);
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_disp;
    logic [4*DIGITS-1:0]    r_shadow;
    logic                   r_pending;
    logic                   r_frame_tick;

    logic                   w_wrap;
    logic                   w_commit;
    logic [3:0]             w_nibble;
    logic [DIGITS-1:0]      w_onehot;
    logic                   w_sel_dark;
    logic [DIGITS-1:0]      w_digit_en;
    logic [DIGITS-1:0]      w_extra_dark;

    assign w_wrap   = (r_cnt == CNT_LAST);
    assign w_commit = w_wrap && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_commit;
            if (w_wrap) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_commit && r_pending) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
            end
            // A load on the commit edge lands after the commit, so pending stays set.
            if (bus.load) begin
                r_shadow  <= bus.value;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zero_run;

    // Walk from the most significant digit down; digit 0 is always exempt.
    always_comb begin
        int unsigned i;
        w_extra_dark = '0;
        w_zero_run   = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            i          = DIGITS - 1 - k;
            w_zero_run = w_zero_run & (r_disp[i*4 +: 4] == 4'h0);
            if (i != 0) begin
                w_extra_dark[i] = w_zero_run;
            end
        end
    end
`else
    assign w_extra_dark = '0;
`endif

    always_comb begin
        w_nibble   = '0;
        w_onehot   = '0;
        w_sel_dark = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nibble    = r_disp[i*4 +: 4];
                w_onehot[i] = 1'b1;
                w_sel_dark  = bus.blank_mask[i] | w_extra_dark[i];
            end
        end
    end

    assign w_digit_en = ((r_cnt >= GUARD_CNT) && !w_sel_dark) ? w_onehot : '0;

    assign bus.nibble     = w_nibble;
    assign bus.digit_en   = w_digit_en;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux (DIGITS=4, PRESCALE=8, GUARD=2).
// A cycle-time reference model pushes expected state; a negedge monitor pops and compares.
module tb_disp_scan_mux;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 8;
    localparam int unsigned GUARD    = 2;
    localparam int unsigned FRAME    = DIGITS * PRESCALE;

    typedef struct {
        logic [4*DIGITS-1:0] shown;
        int unsigned         slot;
        int unsigned         phase;
        logic                tick;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    int unsigned         m_t;
    logic [4*DIGITS-1:0] m_shown;
    logic [4*DIGITS-1:0] m_pend_val;
    logic                m_pend;
    logic                m_tick;

    disp_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    disp_scan_mux #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE),
        .GUARD   (GUARD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: m_t counts cycles since reset; slot/phase/frame follow by division.
    initial begin
        exp_t e;
        m_t = 0; m_shown = '0; m_pend_val = '0; m_pend = 1'b0; m_tick = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_t = 0; m_shown = '0; m_pend_val = '0; m_pend = 1'b0; m_tick = 1'b0;
            end else begin
                m_tick = ((m_t % FRAME) == FRAME - 1);
                if (m_tick && m_pend) begin
                    m_shown = m_pend_val;
                    m_pend  = 1'b0;
                end
                if (bus.load) begin
                    m_pend_val = bus.value;
                    m_pend     = 1'b1;
                end
                m_t++;
            end
            e.shown = m_shown;
            e.slot  = (m_t / PRESCALE) % DIGITS;
            e.phase = m_t % PRESCALE;
            e.tick  = m_tick;
            sb_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        logic [3:0]        exp_nib;
        logic [DIGITS-1:0] exp_en;
        logic              dark;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e       = sb_q.pop_front();
                exp_nib = e.shown[e.slot*4 +: 4];
                dark    = bus.blank_mask[e.slot];
`ifdef LEADING_ZERO_BLANK_EN
                if (e.slot > 0 && (e.shown >> (e.slot*4)) == '0) dark = 1'b1;
`endif
                exp_en = (e.phase >= GUARD && !dark) ? DIGITS'(1 << e.slot) : '0;
                checks += 3;
                if (bus.nibble !== exp_nib) begin
                    failures++;
                    $display("FAIL nibble t=%0t got=%h want=%h", $time, bus.nibble, exp_nib);
                end
                if (bus.digit_en !== exp_en) begin
                    failures++;
                    $display("FAIL digit_en t=%0t got=%b want=%b", $time, bus.digit_en, exp_en);
                end
                if (bus.frame_tick !== e.tick) begin
                    failures++;
                    $display("FAIL frame_tick t=%0t got=%b want=%b", $time, bus.frame_tick, e.tick);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        step(1);
        bus.load  = 1'b0;
    endtask

    task automatic wait_phase(input int unsigned p);
        int unsigned n;
        n = 0;
        while ((m_t % FRAME) != p && n < 4 * FRAME) begin
            step(1);
            n++;
        end
        checks++;
        if ((m_t % FRAME) != p) begin
            failures++;
            $display("FAIL wait_phase got=%0d want=%0d", m_t % FRAME, p);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.load = 1'b0; bus.value = '0; bus.blank_mask = '0;
        step(3);
        rst_n = 1'b1;
        step(40);

        wait_phase(11);
        do_load(16'h1234);
        step(70);

        wait_phase(3);
        do_load(16'h1111);
        wait_phase(20);
        do_load(16'h2222);
        step(70);

        wait_phase(FRAME - 1);
        do_load(16'hABCD);
        step(70);

        bus.blank_mask = 4'b0100;
        step(40);
        wait_phase(19);
        bus.blank_mask = '0;
        step(40);

        do_load(16'h0050);
        step(70);
        do_load(16'h0000);
        step(70);

        wait_phase(5);
        do_load(16'h9876);
        step(4);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(80);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.load  = 1'b1;
                bus.value = 16'($urandom);
            end else begin
                bus.load  = 1'b0;
            end
            if ($urandom_range(0, 29) == 0) bus.blank_mask = 4'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            step(1);
        end
        bus.load = 1'b0;
        rst_n    = 1'b1;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
